gpio_input_filter: RTL and testbench



---
 rtl/gpio_input_filter_if.sv | 31 +++
 rtl/gpio_input_filter.sv | 79 +++++++
 tb/tb_gpio_input_filter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gpio_input_filter_if.sv
// Bus bundle between the GPIO register file and the input filter stage:
// raw pads and debounce configuration in, filtered level and edge pulses out.
interface gpio_input_filter_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     gpio_in;
  logic [WIDTH-1:0]     debounce_en;
  logic [CNT_WIDTH-1:0] debounce_limit;
  logic [WIDTH-1:0]     idr;
  logic [WIDTH-1:0]     rise;
  logic [WIDTH-1:0]     fall;

  modport master (
    output gpio_in,
    output debounce_en,
    output debounce_limit,
    input  idr,
    input  rise,
    input  fall
  );

  modport slave (
    input  gpio_in,
    input  debounce_en,
    input  debounce_limit,
    output idr,
    output rise,
    output fall
  );
endinterface

// File: rtl/gpio_input_filter.sv
// Per-pin synchronizer plus optional stability-counter debounce, producing the
// filtered IDR level and single-cycle rise/fall pulses for the status logic.
module gpio_input_filter #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_input_filter_if.slave   bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]     sync_val;
  logic [WIDTH-1:0]     s_q;
  logic [WIDTH-1:0]     s_next;
  logic [WIDTH-1:0]     rise_q;
  logic [WIDTH-1:0]     fall_q;
  logic [CNT_WIDTH-1:0] cnt_q    [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_next [WIDTH];

  // Plain flop chain with nothing in between, so each stage has a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.gpio_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];

  // The >= compare lets the limit drop mid-count without the counter wrapping.
  always_comb begin
    s_next = s_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (!bus.debounce_en[i]) begin
        s_next[i] = sync_val[i];
      end else if (sync_val[i] != s_q[i]) begin
        if (cnt_q[i] >= bus.debounce_limit) begin
          s_next[i] = sync_val[i];
        end else begin
          cnt_next[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      rise_q <= '0;
      fall_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s_q    <= s_next;
      rise_q <= ~s_q & s_next;
      fall_q <= s_q & ~s_next;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_next[i];
      end
    end
  end

  assign bus.idr  = s_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;

endmodule

// File: tb/tb_gpio_input_filter.sv
// Randomized and directed bench for gpio_input_filter, checked against a
// history-based reference model of the synchronize-then-debounce behaviour.
module tb_gpio_input_filter;

  localparam int WIDTH       = 32;
  localparam int SYNC_STAGES = 2;
  localparam int CNT_WIDTH   = 16;
  localparam int HMAX        = 256;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  gpio_input_filter_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  gpio_input_filter #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [WIDTH-1:0]     cur_in;
  logic [WIDTH-1:0]     cur_en;
  logic [CNT_WIDTH-1:0] cur_lim;

  // Reference model: a delay line for the synchronizer and, per pin, the
  // history of synchronized samples; a level is accepted once the trailing
  // run of samples disagreeing with it is longer than the current limit.
  logic [WIDTH-1:0] delay_q [$];
  logic [WIDTH-1:0] m_s, m_rise, m_fall;
  bit               hist [WIDTH][HMAX];
  int               hist_len [WIDTH];

  task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (obs === exp) passed++;
    else $display("[TB] FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic modelStep(input logic r, input logic [WIDTH-1:0] in_v,
                           input logic [WIDTH-1:0] en_v, input logic [CNT_WIDTH-1:0] lim_v);
    logic [WIDTH-1:0] sync_v;
    logic [WIDTH-1:0] new_s;
    int run;
    if (r) begin
      delay_q.delete();
      for (int k = 0; k < SYNC_STAGES; k++) delay_q.push_back('0);
      m_s = '0; m_rise = '0; m_fall = '0;
      for (int i = 0; i < WIDTH; i++) hist_len[i] = 0;
    end else begin
      sync_v = delay_q.pop_front();
      delay_q.push_back(in_v);
      new_s = m_s;
      for (int i = 0; i < WIDTH; i++) begin
        if (!en_v[i]) begin
          new_s[i] = sync_v[i];
          hist_len[i] = 0;
        end else begin
          if (hist_len[i] == HMAX) begin
            for (int j = 0; j < HMAX - 1; j++) hist[i][j] = hist[i][j+1];
            hist_len[i]--;
          end
          hist[i][hist_len[i]] = sync_v[i];
          hist_len[i]++;
          run = 0;
          for (int j = hist_len[i] - 1; j >= 0; j--) begin
            if (hist[i][j] != m_s[i]) run++;
            else break;
          end
          if (run >= int'(lim_v) + 1) new_s[i] = sync_v[i];
        end
      end
      m_rise = ~m_s & new_s;
      m_fall = m_s & ~new_s;
      m_s    = new_s;
    end
  endtask

  task automatic applyStimulus(input logic r);
    rst                = r;
    bus.gpio_in        = cur_in;
    bus.debounce_en    = cur_en;
    bus.debounce_limit = cur_lim;
    @(posedge clk);
    cyc++;
    modelStep(r, cur_in, cur_en, cur_lim);
    #1;
    checkOutput("idr", bus.idr, m_s);
    checkOutput("rise", bus.rise, m_rise);
    checkOutput("fall", bus.fall, m_fall);
  endtask

  logic pulse7;
  int   roll;

  initial begin
    cur_in = '1; cur_en = '0; cur_lim = '0;

    repeat (3) applyStimulus(1'b1);
    checkOutput("rst_idr", bus.idr, '0);
    checkOutput("rst_rise", bus.rise, '0);
    repeat (3) applyStimulus(1'b0);
    checkOutput("release_rise", bus.rise, '1);
    applyStimulus(1'b0);
    checkOutput("release_rise_once", bus.rise, '0);

    // Bypass on pin 0: low, then high, then low again.
    cur_in = '0; repeat (5) applyStimulus(1'b0);
    cur_in[0] = 1'b1; repeat (5) applyStimulus(1'b0);
    cur_in[0] = 1'b0; repeat (5) applyStimulus(1'b0);

    // Debounce pin 5 with L=4: a 5-cycle pulse passes, a 4-cycle one does not.
    cur_en[5] = 1'b1; cur_lim = 16'd4;
    cur_in[5] = 1'b1; repeat (5) applyStimulus(1'b0);
    cur_in[5] = 1'b0; repeat (12) applyStimulus(1'b0);
    cur_in[5] = 1'b1; repeat (4) applyStimulus(1'b0);
    cur_in[5] = 1'b0; repeat (12) applyStimulus(1'b0);
    checkOutput("pin5_short", {31'b0, bus.idr[5]}, '0);

    // Glitch train on pin 7, L=3, toggling every 2 cycles.
    cur_en[7] = 1'b1; cur_lim = 16'd3; pulse7 = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (t % 2 == 0) cur_in[7] = ~cur_in[7];
      applyStimulus(1'b0);
      pulse7 = pulse7 | bus.rise[7] | bus.fall[7];
    end
    cur_in[7] = 1'b0; repeat (4) applyStimulus(1'b0);
    checkOutput("pin7_pulses", {31'b0, pulse7}, '0);

    // Pin 9: long count under L=100, then the limit drops to 10.
    cur_en[9] = 1'b1; cur_lim = 16'd100;
    cur_in[9] = 1'b1; repeat (52) applyStimulus(1'b0);
    checkOutput("pin9_holding", {31'b0, bus.idr[9]}, '0);
    cur_lim = 16'd10; repeat (3) applyStimulus(1'b0);
    checkOutput("pin9_accept", {31'b0, bus.idr[9]}, 32'd1);

    // Reset mid-count discards progress.
    cur_in[9] = 1'b0; repeat (14) applyStimulus(1'b0);
    cur_lim = 16'd20; cur_in[9] = 1'b1;
    repeat (10) applyStimulus(1'b0);
    applyStimulus(1'b1);
    repeat (15) applyStimulus(1'b0);
    checkOutput("pin9_after_rst", {31'b0, bus.idr[9]}, '0);
    repeat (10) applyStimulus(1'b0);
    checkOutput("pin9_recount", {31'b0, bus.idr[9]}, 32'd1);

    // All pins toggle together with mixed debounce enables.
    cur_en = 32'h0F0F_33CC; cur_lim = 16'd3;
    cur_in = ~cur_in; repeat (10) applyStimulus(1'b0);
    cur_in = ~cur_in; repeat (10) applyStimulus(1'b0);

    // Random traffic: sparse pin changes, occasional config changes and resets.
    for (int t = 0; t < 1500; t++) begin
      roll = int'($urandom_range(0, 199));
      if (roll < 50) cur_in = cur_in ^ ($urandom & $urandom & $urandom);
      if (roll == 60 || roll == 61 || roll == 62) cur_en = $urandom;
      if (roll >= 70 && roll < 75) cur_lim = 16'($urandom_range(0, 6));
      applyStimulus(roll == 199);
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
